// File: rtl/tcdm_bridge_pkg.sv
// Shared helpers for the multi-channel TCDM bridge: request word layout,
// id/counter widths and the arbiter lock states.
package tcdm_bridge_pkg;

    // Request word is packed {addr, be, wdata, wen}; wen sits at bit 0.
    localparam int unsigned WEN_OFS   = 0;
    localparam int unsigned WDATA_OFS = 1;

    typedef enum logic {
        ARB_FREE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

    function automatic int unsigned req_w(input int unsigned addr_w, input int unsigned data_w);
        return addr_w + data_w / 8 + data_w + 1;
    endfunction

    function automatic int unsigned be_ofs(input int unsigned data_w);
        return WDATA_OFS + data_w;
    endfunction

    function automatic int unsigned addr_ofs(input int unsigned data_w);
        return WDATA_OFS + data_w + data_w / 8;
    endfunction

    function automatic int unsigned ch_id_w(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tcdm_sync_fifo.sv
// Single-clock FIFO with synchronous flush; head is read straight from the
// storage registers so it is stable until the entry is popped.
module tcdm_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_en;
    logic             pop_en;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_en)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/tcdm_mux_bridge.sv
// NUM_CH eFPGA TCDM masters round-robin muxed onto one SoC TCDM port, with
// in-order response routing through a tag FIFO and a bounded outstanding count.
module tcdm_mux_bridge
    import tcdm_bridge_pkg::*;
#(
    parameter  int unsigned NUM_CH    = 4,
    parameter  int unsigned ADDR_W    = 20,
    parameter  int unsigned DATA_W    = 32,
    parameter  int unsigned REQ_DEPTH = 4,
    parameter  int unsigned MAX_OUTST = 4,
    localparam int unsigned REQ_W     = req_w(ADDR_W, DATA_W)
) (
    input  logic                    soc_clk,
    input  logic                    soc_rst,
    input  logic [NUM_CH-1:0]       efpga_req,
    output logic [NUM_CH-1:0]       efpga_gnt,
    input  logic [NUM_CH*REQ_W-1:0] efpga_req_data,
    output logic [NUM_CH-1:0]       efpga_valid,
    output logic [DATA_W-1:0]       efpga_rdata,
    output logic                    soc_req,
    input  logic                    soc_gnt,
    output logic [REQ_W-1:0]        soc_req_data,
    input  logic                    soc_valid,
    input  logic [DATA_W-1:0]       soc_rdata,
    output logic                    err_unexp_valid
);

    localparam int unsigned CH_W = ch_id_w(NUM_CH);
    localparam int unsigned OW   = cnt_w(MAX_OUTST);

    logic [NUM_CH-1:0] req_full;
    logic [NUM_CH-1:0] req_empty;
    logic [NUM_CH-1:0] req_push;
    logic [NUM_CH-1:0] req_pop;
    logic [REQ_W-1:0]  req_head [NUM_CH];

    arb_state_e        arb_state;
    arb_state_e        arb_next;
    logic [CH_W-1:0]   lock_ch;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   sel_c;
    logic [OW-1:0]     outst;
    logic [CH_W-1:0]   tag_head;
    logic              tag_full;
    logic              tag_empty;
    logic              can_issue;
    logic              issue;
    logic              resp_fire;

    // First non-empty channel at or after the round-robin pointer.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] elig,
                                                input logic [CH_W-1:0]   ptr);
        logic [CH_W-1:0] pick;
        logic            found;
        int unsigned     idx;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = (32'(ptr) + i) % NUM_CH;
            if (!found && elig[CH_W'(idx)]) begin
                pick  = CH_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_req_fifo
        assign req_push[c] = efpga_req[c] & ~req_full[c];
        assign req_pop[c]  = issue & (sel_c == CH_W'(c));

        tcdm_sync_fifo #(
            .WIDTH (REQ_W),
            .DEPTH (REQ_DEPTH)
        ) u_req_fifo (
            .clk       (soc_clk),
            .flush     (soc_rst),
            .push      (req_push[c]),
            .push_data (efpga_req_data[c*REQ_W +: REQ_W]),
            .pop       (req_pop[c]),
            .head      (req_head[c]),
            .full      (req_full[c]),
            .empty     (req_empty[c])
        );
    end

    // Channel id of every issued request, popped in order as responses return.
    tcdm_sync_fifo #(
        .WIDTH (CH_W),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk       (soc_clk),
        .flush     (soc_rst),
        .push      (issue),
        .push_data (sel_c),
        .pop       (resp_fire),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    assign efpga_gnt    = ~req_full;
    assign can_issue    = (outst < OW'(MAX_OUTST)) & ~tag_full;
    assign soc_req      = (|(~req_empty)) & can_issue;
    assign soc_req_data = req_head[sel_c];
    assign issue        = soc_req & soc_gnt;
    assign resp_fire    = soc_valid & ~tag_empty;

    always_ff @(posedge soc_clk) begin
        if (soc_rst) arb_state <= ARB_FREE;
        else         arb_state <= arb_next;
    end

    // A pending but ungranted request pins the selection until it is granted.
    always_comb begin
        arb_next = arb_state;
        case (arb_state)
            ARB_FREE: if (soc_req && !soc_gnt) arb_next = ARB_HOLD;
            ARB_HOLD: if (issue)               arb_next = ARB_FREE;
            default:                           arb_next = ARB_FREE;
        endcase
    end

    always_comb begin
        sel_c = rr_pick(~req_empty, rr_ptr);
        if (arb_state == ARB_HOLD) sel_c = lock_ch;
    end

    always_ff @(posedge soc_clk) begin
        if (soc_rst) begin
            lock_ch <= '0;
            rr_ptr  <= '0;
            outst   <= '0;
        end else begin
            if (soc_req && !soc_gnt) lock_ch <= sel_c;
            if (issue) rr_ptr <= (sel_c == CH_W'(NUM_CH - 1)) ? '0 : sel_c + CH_W'(1);
            outst <= outst + OW'(issue) - OW'(resp_fire);
        end
    end

    // Response strobe/data registered one cycle after soc_valid.
    always_ff @(posedge soc_clk) begin
        if (soc_rst) begin
            efpga_valid     <= '0;
            efpga_rdata     <= '0;
            err_unexp_valid <= 1'b0;
        end else begin
            efpga_valid <= resp_fire ? (NUM_CH'(1) << tag_head) : '0;
            if (resp_fire)              efpga_rdata     <= soc_rdata;
            if (soc_valid && tag_empty) err_unexp_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tcdm_mux_bridge.sv
// Randomized bench for tcdm_mux_bridge: queue-level reference of the request
// path plus a response scoreboard drained by an independent monitor.
module tb_tcdm_mux_bridge;
    import tcdm_bridge_pkg::*;

    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned ADDR_W    = 20;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REQ_DEPTH = 4;
    localparam int unsigned MAX_OUTST = 4;
    localparam int unsigned REQ_W     = req_w(ADDR_W, DATA_W);
    localparam int unsigned BE_W      = DATA_W / 8;
    localparam longint      PERIOD    = 10;

    logic                    soc_clk = 1'b0;
    logic                    soc_rst;
    logic [NUM_CH-1:0]       efpga_req;
    logic [NUM_CH-1:0]       efpga_gnt;
    logic [NUM_CH*REQ_W-1:0] efpga_req_data;
    logic [NUM_CH-1:0]       efpga_valid;
    logic [DATA_W-1:0]       efpga_rdata;
    logic                    soc_req;
    logic                    soc_gnt;
    logic [REQ_W-1:0]        soc_req_data;
    logic                    soc_valid;
    logic [DATA_W-1:0]       soc_rdata;
    logic                    err_unexp_valid;

    tcdm_mux_bridge #(
        .NUM_CH    (NUM_CH),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .REQ_DEPTH (REQ_DEPTH),
        .MAX_OUTST (MAX_OUTST)
    ) dut (
        .soc_clk         (soc_clk),
        .soc_rst         (soc_rst),
        .efpga_req       (efpga_req),
        .efpga_gnt       (efpga_gnt),
        .efpga_req_data  (efpga_req_data),
        .efpga_valid     (efpga_valid),
        .efpga_rdata     (efpga_rdata),
        .soc_req         (soc_req),
        .soc_gnt         (soc_gnt),
        .soc_req_data    (soc_req_data),
        .soc_valid       (soc_valid),
        .soc_rdata       (soc_rdata),
        .err_unexp_valid (err_unexp_valid)
    );

    always #(PERIOD / 2) soc_clk = ~soc_clk;

    typedef struct {
        int                ch;
        logic [DATA_W-1:0] data;
        longint            due;
    } resp_t;

    // Reference state: one queue per channel, in-order list of issued channel ids.
    logic [REQ_W-1:0] mq [NUM_CH][$];
    int               outst_q[$];
    resp_t            exp_resp[$];
    int               rr      = 0;
    bit               lock_v  = 1'b0;
    int               lock_ch = 0;
    bit               err_exp = 1'b0;
    bit [NUM_CH-1:0]  acc     = '0;

    int n_checks   = 0;
    int n_errors   = 0;
    int dut_issues = 0;

    // Driver state and knobs (percent probabilities).
    bit               pend_v [NUM_CH];
    logic [REQ_W-1:0] pend_d [NUM_CH];
    int unsigned      p_req   = 0;
    int unsigned      p_gnt   = 100;
    int unsigned      p_valid = 0;
    bit               rst_knob    = 1'b1;
    bit               force_valid = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge soc_clk) begin : model
        int              sel;
        int              ch;
        bit              exp_req;
        logic [NUM_CH-1:0] exp_gnt;

        for (int c = 0; c < NUM_CH; c++) exp_gnt[c] = (mq[c].size() < REQ_DEPTH);
        chk("efpga_gnt", 64'(efpga_gnt), 64'(exp_gnt));

        exp_req = 1'b0;
        for (int c = 0; c < NUM_CH; c++) if (mq[c].size() > 0) exp_req = 1'b1;
        if (outst_q.size() >= MAX_OUTST) exp_req = 1'b0;
        chk("soc_req", 64'(soc_req), 64'(exp_req));

        sel = lock_v ? lock_ch : -1;
        if (!lock_v) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ch = (rr + i) % NUM_CH;
                if (sel < 0 && mq[ch].size() > 0) sel = ch;
            end
        end
        if (exp_req) chk("soc_req_data", 64'(soc_req_data), 64'(mq[sel][0]));
        chk("err_unexp_valid", 64'(err_unexp_valid), 64'(err_exp));

        if (soc_rst) begin
            for (int c = 0; c < NUM_CH; c++) mq[c].delete();
            outst_q.delete();
            rr      = 0;
            lock_v  = 1'b0;
            err_exp = 1'b0;
            acc     = '0;
        end else begin
            if (soc_valid) begin
                if (outst_q.size() > 0) begin
                    ch = outst_q.pop_front();
                    exp_resp.push_back('{ch, soc_rdata, longint'($time) + PERIOD});
                end else begin
                    err_exp = 1'b1;
                end
            end
            if (exp_req) begin
                if (soc_gnt) begin
                    void'(mq[sel].pop_front());
                    outst_q.push_back(sel);
                    rr     = (sel + 1) % NUM_CH;
                    lock_v = 1'b0;
                end else begin
                    lock_v  = 1'b1;
                    lock_ch = sel;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] = efpga_req[c] & exp_gnt[c];
                if (acc[c]) mq[c].push_back(efpga_req_data[c*REQ_W +: REQ_W]);
            end
        end
    end

    logic [DATA_W-1:0] last_rdata = '0;

    always @(negedge soc_clk) begin : monitor
        resp_t e;
        if (soc_req === 1'b1 && soc_gnt === 1'b1) dut_issues++;
        if (efpga_valid !== '0) begin
            if (exp_resp.size() == 0) begin
                chk("resp_unexpected", 64'(efpga_valid), 64'(0));
            end else begin
                e = exp_resp.pop_front();
                chk("resp_valid", 64'(efpga_valid), 64'(NUM_CH'(1) << e.ch));
                chk("resp_rdata", 64'(efpga_rdata), 64'(e.data));
                chk("resp_latency", 64'($time), 64'(e.due));
                last_rdata = e.data;
            end
        end else begin
            chk("rdata_hold", 64'(efpga_rdata), 64'(last_rdata));
            if (exp_resp.size() > 0 && exp_resp[0].due <= longint'($time)) begin
                chk("resp_missing", 64'(exp_resp.size()), 64'(0));
                void'(exp_resp.pop_front());
            end
        end
        if (soc_rst) last_rdata = '0;
    end

    task automatic cycle_drive();
        @(posedge soc_clk);
        #1;
        soc_rst = rst_knob;
        for (int c = 0; c < NUM_CH; c++) begin
            if (acc[c] || !pend_v[c]) begin
                pend_v[c] = ($urandom_range(99) < p_req);
                pend_d[c] = REQ_W'({$urandom(), $urandom()});
            end
            efpga_req[c]                      = pend_v[c];
            efpga_req_data[c*REQ_W +: REQ_W] = pend_d[c];
        end
        soc_gnt   = ($urandom_range(99) < p_gnt);
        soc_valid = force_valid || (outst_q.size() > 0 && $urandom_range(99) < p_valid);
        soc_rdata = $urandom();
    endtask

    initial begin : driver
        logic [REQ_W-1:0] t1;
        int               base;

        soc_rst        = 1'b1;
        efpga_req      = '0;
        efpga_req_data = '0;
        soc_gnt        = 1'b0;
        soc_valid      = 1'b0;
        soc_rdata      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pend_v[c] = 1'b0;
            pend_d[c] = '0;
        end
        repeat (2) cycle_drive();
        rst_knob = 1'b0;

        // Single channel-0 write with a known packed word.
        t1 = '0;
        t1[addr_ofs(DATA_W) +: ADDR_W] = ADDR_W'(20'h00010);
        t1[be_ofs(DATA_W) +: BE_W]     = '1;
        t1[WDATA_OFS +: DATA_W]        = 32'hDEADBEEF;
        t1[WEN_OFS]                    = 1'b1;
        pend_v[0] = 1'b1;
        pend_d[0] = t1;
        cycle_drive();
        cycle_drive();
        @(negedge soc_clk);
        chk("t1_soc_req", 64'(soc_req), 64'(1));
        chk("t1_soc_req_data", 64'(soc_req_data), 64'(t1));
        p_valid = 100;
        repeat (6) cycle_drive();

        // All channels saturating, grant and respond every cycle.
        p_req = 100;
        repeat (40) cycle_drive();

        // Random stalls: exercises the selection lock and response interleaving.
        p_req   = 50;
        p_gnt   = 30;
        p_valid = 50;
        repeat (300) cycle_drive();

        // SoC stalled: request FIFOs fill and back-pressure.
        p_req = 100;
        p_gnt = 0;
        repeat (10) cycle_drive();
        @(negedge soc_clk);
        chk("t5_gnt_all_low", 64'(efpga_gnt), 64'(0));

        p_req   = 0;
        p_gnt   = 100;
        p_valid = 100;
        repeat (30) cycle_drive();

        // Responses withheld: exactly MAX_OUTST issues, then soc_req drops.
        base    = dut_issues;
        p_req   = 100;
        p_valid = 0;
        repeat (12) cycle_drive();
        @(negedge soc_clk);
        chk("t4_grants", 64'(dut_issues - base), 64'(MAX_OUTST));
        chk("t4_soc_req_low", 64'(soc_req), 64'(0));
        force_valid = 1'b1;
        cycle_drive();
        force_valid = 1'b0;
        cycle_drive();
        @(negedge soc_clk);
        chk("t4_reassert", 64'(soc_req), 64'(1));

        // Reset with outstanding requests, then a stale response.
        p_req = 0;
        repeat (3) cycle_drive();
        rst_knob = 1'b1;
        cycle_drive();
        rst_knob    = 1'b0;
        force_valid = 1'b1;
        cycle_drive();
        force_valid = 1'b0;
        cycle_drive();
        @(negedge soc_clk);
        chk("t6_err_sticky", 64'(err_unexp_valid), 64'(1));
        chk("t6_gnt_all_high", 64'(efpga_gnt), 64'({NUM_CH{1'b1}}));

        p_valid = 100;
        repeat (40) cycle_drive();
        @(negedge soc_clk);
        chk("final_resp_drained", 64'(exp_resp.size()), 64'(0));
        chk("final_err_sticky", 64'(err_unexp_valid), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
